// File: rtl/ft_mcs_pkg.sv
// Shared definitions for the MCS MMIO slot peripherals: timer register map,
// CTRL/STATUS bit positions and the Wishbone responder handshake states.
package ft_mcs_pkg;

  localparam int TMR_DATA_W   = 32;
  localparam int TMR_CNT_W    = 48;
  localparam int TMR_REG_BITS = 3;

  localparam logic [TMR_REG_BITS-1:0] TMR_REG_COUNT_LO = 3'd0;
  localparam logic [TMR_REG_BITS-1:0] TMR_REG_COUNT_HI = 3'd1;
  localparam logic [TMR_REG_BITS-1:0] TMR_REG_CTRL     = 3'd2;
  localparam logic [TMR_REG_BITS-1:0] TMR_REG_COMPARE  = 3'd3;
  localparam logic [TMR_REG_BITS-1:0] TMR_REG_STATUS   = 3'd4;

  localparam int CTRL_GO     = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_RELOAD = 2;
  localparam int CTRL_IRQEN  = 3;

  localparam int STAT_MATCH = 0;
  localparam int STAT_OVF   = 1;

  localparam logic [TMR_DATA_W-1:0] TMR_COMPARE_RST = 32'hFFFF_FFFF;

  typedef enum logic {WB_IDLE, WB_RESP} wb_slv_state_t;

endpackage

// File: rtl/wishbone_if.sv
// Classic Wishbone bundle between the MCS bridge (master) and one MMIO slot.
interface wishbone_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  CYC;
  logic                  STB;
  logic                  WE;
  logic [ADDR_WIDTH-1:0] ADDR;
  logic [DATA_WIDTH-1:0] DAT_I;
  logic [DATA_WIDTH-1:0] DAT_O;
  logic                  ACK;

  modport slave  (input CYC, STB, WE, ADDR, DAT_I, output DAT_O, ACK);
  modport master (output CYC, STB, WE, ADDR, DAT_I, input DAT_O, ACK);

endinterface

// File: rtl/wb_timer_core.sv
// Wishbone timer slot: 48-bit counter with compare/auto-reload and a level irq.
// Every access is accepted in IDLE and ACKed from RESP exactly one cycle later.
module wb_timer_core
  import ft_mcs_pkg::*;
#(
  parameter int REG_ADDR_BITS = 3
) (
  input  logic      clk,
  input  logic      reset,
  wishbone_if.slave wb,
  output logic      irq
);

  wb_slv_state_t                  state_q, state_d;
  logic [TMR_DATA_W-1:0]          rdata_q, rdata_d;
  logic [TMR_CNT_W-TMR_DATA_W-1:0] hi_shadow_q, hi_shadow_d;
  logic [3:0]                     ctrl_q, ctrl_d;
  logic [TMR_DATA_W-1:0]          compare_q, compare_d;
  logic [TMR_CNT_W-1:0]           count_q, count_d;
  logic [1:0]                     status_q, status_d;

  logic [REG_ADDR_BITS-1:0] reg_idx;
  logic                     req, wr_en, rd_en;
  logic                     sel_lo, sel_hi, sel_ctrl, sel_cmp, sel_stat;
  logic [TMR_DATA_W-1:0]    rd_mux;
  logic                     clear_wr, match_hit, reload_hit, wrap_hit;
  logic [1:0]               status_set, status_w1c;
  logic                     unused_addr;

  // Upper address bits select the slot upstream and are deliberately ignored.
  assign reg_idx     = wb.ADDR[REG_ADDR_BITS-1:0];
  assign unused_addr = ^wb.ADDR;

  assign req   = (state_q == WB_IDLE) && wb.CYC && wb.STB;
  assign wr_en = req && wb.WE;
  assign rd_en = req && !wb.WE;

  assign sel_lo   = (reg_idx == REG_ADDR_BITS'(TMR_REG_COUNT_LO));
  assign sel_hi   = (reg_idx == REG_ADDR_BITS'(TMR_REG_COUNT_HI));
  assign sel_ctrl = (reg_idx == REG_ADDR_BITS'(TMR_REG_CTRL));
  assign sel_cmp  = (reg_idx == REG_ADDR_BITS'(TMR_REG_COMPARE));
  assign sel_stat = (reg_idx == REG_ADDR_BITS'(TMR_REG_STATUS));

  always_comb begin
    rd_mux = '0;
    if (sel_lo)        rd_mux = count_q[TMR_DATA_W-1:0];
    else if (sel_hi)   rd_mux = {16'h0, hi_shadow_q};
    else if (sel_ctrl) rd_mux = {28'h0, ctrl_q};
    else if (sel_cmp)  rd_mux = compare_q;
    else if (sel_stat) rd_mux = {30'h0, status_q};
  end

  // rdata defaults to zero so DAT_O is only non-zero during the RESP cycle.
  always_comb begin
    state_d     = state_q;
    rdata_d     = '0;
    hi_shadow_d = hi_shadow_q;
    ctrl_d      = ctrl_q;
    compare_d   = compare_q;
    case (state_q)
      WB_IDLE: begin
        if (req) state_d = WB_RESP;
        if (rd_en) rdata_d = rd_mux;
        if (rd_en && sel_lo) hi_shadow_d = count_q[TMR_CNT_W-1:TMR_DATA_W];
        if (wr_en && sel_ctrl) begin
          ctrl_d           = wb.DAT_I[3:0];
          ctrl_d[CTRL_CLR] = 1'b0;
        end
        if (wr_en && sel_cmp) compare_d = wb.DAT_I[TMR_DATA_W-1:0];
      end
      WB_RESP: state_d = WB_IDLE;
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WB_IDLE;
      rdata_q     <= '0;
      hi_shadow_q <= '0;
      ctrl_q      <= '0;
      compare_q   <= TMR_COMPARE_RST;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      hi_shadow_q <= hi_shadow_d;
      ctrl_q      <= ctrl_d;
      compare_q   <= compare_d;
    end
  end

  assign clear_wr   = wr_en && sel_ctrl && wb.DAT_I[CTRL_CLR];
  assign match_hit  = ctrl_q[CTRL_GO] && (count_q[TMR_DATA_W-1:0] == compare_q);
  assign reload_hit = match_hit && ctrl_q[CTRL_RELOAD];
  assign wrap_hit   = ctrl_q[CTRL_GO] && (count_q == '1) && !clear_wr && !reload_hit;
  assign status_w1c = (wr_en && sel_stat) ? wb.DAT_I[STAT_OVF:STAT_MATCH] : 2'b00;

  always_comb begin
    status_set             = 2'b00;
    status_set[STAT_MATCH] = match_hit;
    status_set[STAT_OVF]   = wrap_hit;
    // Hardware set is OR-ed after the W1C mask so a same-cycle event is never lost.
    status_d = (status_q & ~status_w1c) | status_set;
    count_d  = count_q;
    if (clear_wr)             count_d = '0;
    else if (reload_hit)      count_d = '0;
    else if (ctrl_q[CTRL_GO]) count_d = count_q + 48'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      status_q <= '0;
    end else begin
      count_q  <= count_d;
      status_q <= status_d;
    end
  end

  assign wb.ACK   = (state_q == WB_RESP);
  assign wb.DAT_O = (state_q == WB_RESP) ? rdata_q : '0;
  assign irq      = status_q[STAT_MATCH] && ctrl_q[CTRL_IRQEN];

endmodule

// File: tb/tb_wb_timer_core.sv
// Self-checking bench for wb_timer_core: bus protocol, counter timing derived
// from clock-edge arithmetic, compare/irq behaviour, W1C races and reset abort.
module tb_wb_timer_core;
  import ft_mcs_pkg::*;

  logic clk;
  logic reset;
  logic irq;
  int unsigned cycCnt = 0;
  int checks = 0;
  int errors = 0;
  int unsigned lastEdge = 0;
  logic [47:0] mCount;

  wishbone_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wbBus ();

  wb_timer_core #(.REG_ADDR_BITS(3)) dut (
    .clk  (clk),
    .reset(reset),
    .wb   (wbBus),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge index: at a negedge, cycCnt equals the number of posedges so far.
  always @(posedge clk) cycCnt <= cycCnt + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // One bus transaction; records the commit edge in lastEdge.
  task automatic busXfer(input bit sync, input bit we, input logic [2:0] idx,
                         input logic [31:0] wdata, output logic [31:0] rdata);
    logic [31:0] addr;
    int lat;
    bit got;
    if (sync) @(negedge clk);
    addr = $urandom();
    addr[2:0] = idx;
    wbBus.CYC = 1'b1;
    wbBus.STB = 1'b1;
    wbBus.WE = we;
    wbBus.ADDR = addr;
    wbBus.DAT_I = wdata;
    rdata = '0;
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      lat = k;
      if (wbBus.ACK === 1'b1) got = 1'b1;
      else begin
        checks++;
        if (wbBus.DAT_O !== 32'h0) begin
          errors++;
          $display("[TB] FAIL dat_o_idle: got %h expected 0", wbBus.DAT_O);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL ack_timeout: no ACK within %0d cycles for index %0d", lat, idx);
    end else if (lat != 1) begin
      errors++;
      $display("[TB] FAIL ack_latency: got %0d expected 1", lat);
    end
    lastEdge = cycCnt;
    rdata = wbBus.DAT_O;
    wbBus.CYC = 1'b0;
    wbBus.STB = 1'b0;
    wbBus.WE = 1'b0;
    @(negedge clk);
    checks++;
    if (wbBus.ACK !== 1'b0 || wbBus.DAT_O !== 32'h0) begin
      errors++;
      $display("[TB] FAIL ack_width: ack %b dat %h expected 0/0", wbBus.ACK, wbBus.DAT_O);
    end
  endtask

  task automatic wbWrite(input logic [2:0] idx, input logic [31:0] data);
    logic [31:0] dummy;
    busXfer(1'b1, 1'b1, idx, data, dummy);
  endtask

  task automatic wbRead(input logic [2:0] idx, output logic [31:0] data);
    busXfer(1'b1, 1'b0, idx, 32'h0, data);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] expTab [8];
    expTab = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    reset = 1'b1;
    wbBus.CYC = 1'b0;
    wbBus.STB = 1'b0;
    wbBus.WE = 1'b0;
    wbBus.ADDR = '0;
    wbBus.DAT_I = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (wbBus.ACK !== 1'b0 || wbBus.DAT_O !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: ack %b dat %h irq %b expected 0", wbBus.ACK, wbBus.DAT_O, irq);
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wbRead(3'(i), rd);
      checks++;
      if (rd !== expTab[i]) begin
        errors++;
        $display("[TB] FAIL reset_reg%0d: got %h expected %h", i, rd, expTab[i]);
      end
    end
  endtask

  task automatic test_count_run();
    logic [31:0] rd;
    int unsigned a, b;
    wbWrite(TMR_REG_CTRL, 32'h1);
    a = lastEdge;
    repeat (100) @(negedge clk);
    wbWrite(TMR_REG_CTRL, 32'h0);
    b = lastEdge;
    mCount = 48'(b - a);
    wbRead(TMR_REG_COUNT_LO, rd);
    checks++;
    if (rd !== mCount[31:0]) begin
      errors++;
      $display("[TB] FAIL run_count_lo: got %h expected %h", rd, mCount[31:0]);
    end
    wbRead(TMR_REG_COUNT_HI, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("[TB] FAIL run_count_hi: got %h expected 0", rd);
    end
  endtask

  task automatic test_hi_snapshot();
    logic [31:0] rd;
    int unsigned a, b;
    @(negedge clk);
    force dut.count_q = 48'h0000_FFFF_FFFF;
    @(negedge clk);
    release dut.count_q;
    mCount = 48'h0000_FFFF_FFFF;
    wbRead(TMR_REG_COUNT_LO, rd);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL snap_lo: got %h expected ffffffff", rd);
    end
    wbWrite(TMR_REG_CTRL, 32'h1);
    a = lastEdge;
    repeat (20) @(negedge clk);
    wbWrite(TMR_REG_CTRL, 32'h0);
    b = lastEdge;
    mCount = mCount + 48'(b - a);
    wbRead(TMR_REG_COUNT_HI, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("[TB] FAIL snap_hi_held: got %h expected 0", rd);
    end
    wbRead(TMR_REG_COUNT_LO, rd);
    checks++;
    if (rd !== mCount[31:0]) begin
      errors++;
      $display("[TB] FAIL snap_lo_wrapped: got %h expected %h", rd, mCount[31:0]);
    end
    wbRead(TMR_REG_COUNT_HI, rd);
    checks++;
    if (rd !== {16'h0, mCount[47:32]}) begin
      errors++;
      $display("[TB] FAIL snap_hi_new: got %h expected %h", rd, {16'h0, mCount[47:32]});
    end
    wbRead(TMR_REG_STATUS, rd);
    checks++;
    if (rd !== 32'h1 || irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL snap_status: got %h irq %b expected 1 irq 0", rd, irq);
    end
    wbWrite(TMR_REG_STATUS, 32'h3);
    @(negedge clk);
    force dut.count_q = 48'hFFFF_FFFF_FFF0;
    @(negedge clk);
    release dut.count_q;
    mCount = 48'hFFFF_FFFF_FFF0;
    wbWrite(TMR_REG_CTRL, 32'h1);
    a = lastEdge;
    repeat (30) @(negedge clk);
    wbWrite(TMR_REG_CTRL, 32'h0);
    b = lastEdge;
    mCount = mCount + 48'(b - a);
    wbRead(TMR_REG_COUNT_LO, rd);
    checks++;
    if (rd !== mCount[31:0]) begin
      errors++;
      $display("[TB] FAIL wrap48_lo: got %h expected %h", rd, mCount[31:0]);
    end
    wbRead(TMR_REG_COUNT_HI, rd);
    checks++;
    if (rd !== {16'h0, mCount[47:32]}) begin
      errors++;
      $display("[TB] FAIL wrap48_hi: got %h expected %h", rd, {16'h0, mCount[47:32]});
    end
    wbRead(TMR_REG_STATUS, rd);
    checks++;
    if (rd !== 32'h3) begin
      errors++;
      $display("[TB] FAIL wrap48_status: got %h expected 3", rd);
    end
    wbWrite(TMR_REG_STATUS, 32'h3);
    wbRead(TMR_REG_STATUS, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("[TB] FAIL w1c_clear: got %h expected 0", rd);
    end
  endtask

  task automatic test_compare_irq();
    logic [31:0] rd;
    logic [31:0] dummy;
    int unsigned cmp, period, s, r;
    bit found;
    cmp = $urandom_range(6, 20);
    period = cmp + 1;
    wbWrite(TMR_REG_CTRL, 32'h2);
    wbWrite(TMR_REG_STATUS, 32'h3);
    wbWrite(TMR_REG_COMPARE, cmp);
    wbWrite(TMR_REG_CTRL, 32'hD);
    s = lastEdge;
    repeat (3 * period) @(negedge clk);
    wbRead(TMR_REG_COUNT_LO, rd);
    r = lastEdge;
    checks++;
    if (rd !== 32'((r - 1 - s) % period)) begin
      errors++;
      $display("[TB] FAIL reload_count: got %h expected %h", rd, 32'((r - 1 - s) % period));
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL irq_on_match: got %b expected 1", irq);
    end
    wbRead(TMR_REG_STATUS, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("[TB] FAIL match_status: got %h expected 1", rd);
    end
    wbWrite(TMR_REG_CTRL, 32'hC);
    wbWrite(TMR_REG_STATUS, 32'h1);
    wbRead(TMR_REG_STATUS, rd);
    checks++;
    if (rd !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL match_w1c: got %h irq %b expected 0 irq 0", rd, irq);
    end
    wbWrite(TMR_REG_CTRL, 32'hF);
    s = lastEdge;
    wbRead(TMR_REG_CTRL, rd);
    checks++;
    if (rd !== 32'hD) begin
      errors++;
      $display("[TB] FAIL ctrl_clr_reads0: got %h expected d", rd);
    end
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if ((cycCnt - s) % period == cmp) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL match_cycle_timeout: match cycle not reached");
    end
    busXfer(1'b0, 1'b1, TMR_REG_STATUS, 32'h1, dummy);
    wbWrite(TMR_REG_CTRL, 32'hC);
    wbRead(TMR_REG_STATUS, rd);
    checks++;
    if (rd !== 32'h1 || irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL set_beats_w1c: got %h irq %b expected 1 irq 1", rd, irq);
    end
    wbWrite(TMR_REG_STATUS, 32'h3);
    wbWrite(TMR_REG_CTRL, 32'h0);
  endtask

  task automatic test_clear_go();
    logic [31:0] rd;
    logic [31:0] dummy;
    int unsigned a, e, r, b;
    bit found;
    wbWrite(TMR_REG_CTRL, 32'h2);
    wbWrite(TMR_REG_CTRL, 32'h1);
    a = lastEdge;
    found = 1'b0;
    for (int k = 0; k < 700 && !found; k++) begin
      @(negedge clk);
      if (cycCnt - a == 500) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL count500_timeout: count 500 not reached");
    end
    busXfer(1'b0, 1'b1, TMR_REG_CTRL, 32'h3, dummy);
    e = lastEdge;
    wbRead(TMR_REG_CTRL, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("[TB] FAIL clear_go_ctrl: got %h expected 1", rd);
    end
    wbRead(TMR_REG_COUNT_LO, rd);
    r = lastEdge;
    checks++;
    if (rd !== 32'(r - 1 - e)) begin
      errors++;
      $display("[TB] FAIL clear_go_count: got %h expected %h", rd, 32'(r - 1 - e));
    end
    wbWrite(TMR_REG_CTRL, 32'h0);
    b = lastEdge;
    mCount = 48'(b - e);
    wbRead(TMR_REG_COUNT_LO, rd);
    checks++;
    if (rd !== mCount[31:0]) begin
      errors++;
      $display("[TB] FAIL clear_go_stop: got %h expected %h", rd, mCount[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] val;
    logic expAck;
    val = $urandom();
    wbWrite(TMR_REG_COMPARE, val);
    @(negedge clk);
    wbBus.CYC = 1'b1;
    wbBus.STB = 1'b1;
    wbBus.WE = 1'b0;
    wbBus.ADDR = {29'h0, TMR_REG_COMPARE};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      expAck = (k % 2 == 0);
      checks++;
      if (wbBus.ACK !== expAck) begin
        errors++;
        $display("[TB] FAIL b2b_ack%0d: got %b expected %b", k, wbBus.ACK, expAck);
      end
      if (expAck) begin
        checks++;
        if (wbBus.DAT_O !== val) begin
          errors++;
          $display("[TB] FAIL b2b_data%0d: got %h expected %h", k, wbBus.DAT_O, val);
        end
      end
    end
    wbBus.CYC = 1'b0;
    wbBus.STB = 1'b0;
    @(negedge clk);
    checks++;
    if (wbBus.ACK !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_idle: got %b expected 0", wbBus.ACK);
    end
    wbWrite(TMR_REG_COMPARE, 32'hFFFF_FFFF);
  endtask

  task automatic test_random_regs();
    logic [31:0] rd, data, expv;
    logic [3:0] mCtrl;
    logic [31:0] mCompare;
    logic [2:0] idx;
    logic [2:0] idxTab [5];
    idxTab = '{3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    mCtrl = 4'h0;
    mCompare = $urandom();
    wbWrite(TMR_REG_CTRL, 32'h0);
    wbWrite(TMR_REG_COMPARE, mCompare);
    for (int i = 0; i < 24; i++) begin
      idx = idxTab[$urandom_range(0, 4)];
      data = $urandom();
      if ($urandom_range(0, 1) == 1) begin
        wbWrite(idx, data);
        if (idx == TMR_REG_CTRL) mCtrl = data[3:0] & 4'b1101;
        if (idx == TMR_REG_COMPARE) mCompare = data;
      end else begin
        wbRead(idx, rd);
        if (idx == TMR_REG_CTRL) expv = {28'h0, mCtrl};
        else if (idx == TMR_REG_COMPARE) expv = mCompare;
        else expv = 32'h0;
        checks++;
        if (rd !== expv) begin
          errors++;
          $display("[TB] FAIL rand_read_idx%0d: got %h expected %h", idx, rd, expv);
        end
      end
    end
    wbWrite(TMR_REG_CTRL, 32'h0);
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    @(negedge clk);
    wbBus.CYC = 1'b1;
    wbBus.STB = 1'b1;
    wbBus.WE = 1'b0;
    wbBus.ADDR = {29'h0, TMR_REG_COMPARE};
    @(negedge clk);
    checks++;
    if (wbBus.ACK !== 1'b1) begin
      errors++;
      $display("[TB] FAIL resp_before_reset: got %b expected 1", wbBus.ACK);
    end
    reset = 1'b1;
    wbBus.CYC = 1'b0;
    wbBus.STB = 1'b0;
    @(negedge clk);
    checks++;
    if (wbBus.ACK !== 1'b0 || wbBus.DAT_O !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_in_resp: ack %b dat %h expected 0/0", wbBus.ACK, wbBus.DAT_O);
    end
    reset = 1'b0;
    @(negedge clk);
    wbBus.CYC = 1'b1;
    wbBus.STB = 1'b1;
    wbBus.WE = 1'b1;
    wbBus.ADDR = {29'h0, TMR_REG_COMPARE};
    wbBus.DAT_I = $urandom() & 32'h7FFF_FFFF;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (wbBus.ACK !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_abort_ack: got %b expected 0", wbBus.ACK);
    end
    wbBus.CYC = 1'b0;
    wbBus.STB = 1'b0;
    wbBus.WE = 1'b0;
    reset = 1'b0;
    wbRead(TMR_REG_COMPARE, rd);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL reset_abort_compare: got %h expected ffffffff", rd);
    end
    for (int i = 5; i < 8; i++) begin
      wbWrite(3'(i), $urandom());
      wbRead(3'(i), rd);
      checks++;
      if (rd !== 32'h0) begin
        errors++;
        $display("[TB] FAIL unmapped_idx%0d: got %h expected 0", i, rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_run();
    test_hi_snapshot();
    test_compare_irq();
    test_clear_go();
    test_back_to_back();
    test_random_regs();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
